// File: rtl/ixu_pipe_gen_if.sv
// IXU execute pipe ports: issue handshake, early wakeup, bypass slots,
// ROB completion handshake and PMU counters.
interface ixu_pipe_gen_if #(
   parameter int C_STAGES = 1,
   parameter int P_W      = 6,
   parameter int ROB_W    = 5,
   parameter int C_CNT_W  = 32
);
   logic                          iss_valid_i;
   logic                          iss_ready_o;
   logic [ROB_W-1:0]              iss_rob_i;
   logic [3:0]                    iss_op_i;
   logic [P_W-1:0]                iss_dest_i;
   logic                          iss_wr_i;
   logic                          iss_imm_sel_i;
   logic [31:0]                   iss_imm_i;
   logic [31:0]                   rs1_data_i;
   logic [31:0]                   rs2_data_i;
   logic [P_W-1:0]                wakeup_dest_o;
   logic                          wakeup_valid_o;
   logic [C_STAGES:0]             fwd_valid_o;
   logic [(C_STAGES+1)*P_W-1:0]   fwd_dest_o;
   logic [(C_STAGES+1)*32-1:0]    fwd_data_o;
   logic                          cmp_valid_o;
   logic                          cmp_ready_i;
   logic [ROB_W-1:0]              cmp_rob_o;
   logic [C_CNT_W-1:0]            pmu_issue_cnt_o;
   logic [C_CNT_W-1:0]            pmu_stall_cnt_o;

   modport master (
      output iss_valid_i, iss_rob_i, iss_op_i, iss_dest_i, iss_wr_i,
      output iss_imm_sel_i, iss_imm_i, rs1_data_i, rs2_data_i, cmp_ready_i,
      input  iss_ready_o, wakeup_dest_o, wakeup_valid_o,
      input  fwd_valid_o, fwd_dest_o, fwd_data_o,
      input  cmp_valid_o, cmp_rob_o, pmu_issue_cnt_o, pmu_stall_cnt_o
   );

   modport slave (
      input  iss_valid_i, iss_rob_i, iss_op_i, iss_dest_i, iss_wr_i,
      input  iss_imm_sel_i, iss_imm_i, rs1_data_i, rs2_data_i, cmp_ready_i,
      output iss_ready_o, wakeup_dest_o, wakeup_valid_o,
      output fwd_valid_o, fwd_dest_o, fwd_data_o,
      output cmp_valid_o, cmp_rob_o, pmu_issue_cnt_o, pmu_stall_cnt_o
   );
endinterface

// File: rtl/ixu_pipe_gen.sv
// Parametrised IXU integer execute pipe: ALU in EX, C_STAGES bypass
// stages after it, ROB completion with backpressure and PMU counters.
module ixu_pipe_gen #(
   parameter int C_STAGES = 1,
   parameter int P_W      = 6,
   parameter int ROB_W    = 5,
   parameter int C_CNT_W  = 32
) (
   input logic          core_clock_i,
   input logic          core_reset_i,
   input logic          core_flush_i,
   ixu_pipe_gen_if.slave io
);
   localparam int N = C_STAGES;

   logic                    stall;
   logic                    accept;
   logic [N:0]              v;
   logic [N:0]              w;
   logic [N:0][P_W-1:0]     dest;
   logic [N:0][ROB_W-1:0]   rob;
   logic [N:1][31:0]        sdata;
   logic [31:0]             a;
   logic [31:0]             b;
   logic [3:0]              op;
   logic [31:0]             alu;
   logic [C_CNT_W-1:0]      icnt;
   logic [C_CNT_W-1:0]      scnt;

   assign stall  = v[N] & ~io.cmp_ready_i;
   assign accept = io.iss_valid_i & ~stall;

   assign io.iss_ready_o     = ~stall;
   assign io.wakeup_dest_o   = io.iss_dest_i;
   assign io.wakeup_valid_o  = accept & io.iss_wr_i & (io.iss_dest_i != '0);
   assign io.cmp_valid_o     = v[N];
   assign io.cmp_rob_o       = rob[N];
   assign io.pmu_issue_cnt_o = icnt;
   assign io.pmu_stall_cnt_o = scnt;

   always_comb begin
      alu = '0;
      case (op)
         4'd0:    alu = a + b;
         4'd1:    alu = a - b;
         4'd2:    alu = a & b;
         4'd3:    alu = a | b;
         4'd4:    alu = a ^ b;
         4'd5:    alu = {31'b0, $signed(a) < $signed(b)};
         4'd6:    alu = {31'b0, a < b};
         4'd7:    alu = a << b[4:0];
         4'd8:    alu = a >> b[4:0];
         4'd9:    alu = $signed(a) >>> b[4:0];
         4'd10:   alu = b;
         default: alu = '0;
      endcase
   end

   always_ff @(posedge core_clock_i) begin
      if (core_reset_i) begin
         v     <= '0;
         w     <= '0;
         dest  <= '0;
         rob   <= '0;
         sdata <= '0;
         a     <= '0;
         b     <= '0;
         op    <= '0;
         icnt  <= '0;
         scnt  <= '0;
      end else begin
         if (!stall) begin
            v[0]    <= accept;
            w[0]    <= io.iss_wr_i;
            dest[0] <= io.iss_dest_i;
            rob[0]  <= io.iss_rob_i;
            a       <= io.rs1_data_i;
            b       <= io.iss_imm_sel_i ? io.iss_imm_i : io.rs2_data_i;
            op      <= io.iss_op_i;
            for (int i = 1; i <= N; i++) begin
               v[i]    <= v[i-1];
               w[i]    <= w[i-1];
               dest[i] <= dest[i-1];
               rob[i]  <= rob[i-1];
            end
            sdata[1] <= alu;
            for (int i = 2; i <= N; i++) sdata[i] <= sdata[i-1];
         end
         // Flush wins over both the shift and the stall hold.
         if (core_flush_i) v <= '0;
         if (accept && !core_flush_i && icnt != '1)
            icnt <= icnt + C_CNT_W'(1);
         if (stall && scnt != '1)
            scnt <= scnt + C_CNT_W'(1);
      end
   end

   for (genvar g = 0; g <= N; g++) begin : g_slot
      assign io.fwd_valid_o[g] = v[g] & w[g] & (dest[g] != '0);
      assign io.fwd_dest_o[g*P_W +: P_W] = dest[g];
   end

   assign io.fwd_data_o[31:0] = alu;
   for (genvar g = 1; g <= N; g++) begin : g_data
      assign io.fwd_data_o[g*32 +: 32] = sdata[g];
   end
endmodule

// File: tb/tb_ixu_pipe_gen.sv
// Directed bench: DUT a has three post-EX stages, DUT b has one stage
// and 2-bit PMU counters for the saturation check.
module tb_ixu_pipe_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ixu_pipe_gen_if #(.C_STAGES(3)) ia ();
   ixu_pipe_gen_if #(.C_STAGES(1), .C_CNT_W(2)) ib ();

   ixu_pipe_gen #(.C_STAGES(3)) ua (
      .core_clock_i(clk), .core_reset_i(rst),
      .core_flush_i(flush), .io(ia)
   );
   ixu_pipe_gen #(.C_STAGES(1), .C_CNT_W(2)) ub (
      .core_clock_i(clk), .core_reset_i(rst),
      .core_flush_i(flush), .io(ib)
   );

   logic [3:0]  t_op  [4] = '{4'd1, 4'd9, 4'd6, 4'd10};
   logic [31:0] t_a   [4] = '{32'h0, 32'h8000_0000, 32'h1, 32'h0};
   logic [31:0] t_b   [4] = '{32'h1, 32'h4, 32'hFFFF_FFFF, 32'hDEAD};
   logic [31:0] t_exp [4] = '{32'hFFFF_FFFF, 32'hF800_0000, 32'h1, 32'h1234};

   logic [3:0]  u_op  [7] = '{4'd5, 4'd7, 4'd8, 4'd2, 4'd3, 4'd4, 4'd12};
   logic [31:0] u_a   [7] = '{32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                              32'hF0F0, 32'hF0F0, 32'hFF00, 32'h5};
   logic [31:0] u_b   [7] = '{32'h1, 32'd35, 32'h4,
                              32'h3C3C, 32'h3C3C, 32'h0FF0, 32'h7};
   logic [31:0] u_exp [7] = '{32'h1, 32'h8, 32'h0800_0000,
                              32'h3030, 32'hFCFC, 32'hF0F0, 32'h0};

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic iss_a(input logic vld, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic isel, input logic [31:0] imm,
                        input logic [5:0] d, input logic wr,
                        input logic [4:0] r);
      ia.iss_valid_i = vld; ia.iss_op_i = op;
      ia.rs1_data_i = x; ia.rs2_data_i = y;
      ia.iss_imm_sel_i = isel; ia.iss_imm_i = imm;
      ia.iss_dest_i = d; ia.iss_wr_i = wr; ia.iss_rob_i = r;
   endtask

   task automatic iss_b(input logic vld, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [5:0] d, input logic wr,
                        input logic [4:0] r);
      ib.iss_valid_i = vld; ib.iss_op_i = op;
      ib.rs1_data_i = x; ib.rs2_data_i = y;
      ib.iss_imm_sel_i = 1'b0; ib.iss_imm_i = '0;
      ib.iss_dest_i = d; ib.iss_wr_i = wr; ib.iss_rob_i = r;
   endtask

   initial begin
      iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      iss_b(0, 0, 0, 0, 0, 0, 0);
      ia.cmp_ready_i = 1'b1;
      ib.cmp_ready_i = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_ready_a", ia.iss_ready_o, 1);
      chk("rst_cmp_a", ia.cmp_valid_o, 0);
      chk("rst_fwd_a", ia.fwd_valid_o, 0);
      chk("rst_icnt_a", ia.pmu_issue_cnt_o, 0);
      chk("rst_scnt_a", ia.pmu_stall_cnt_o, 0);
      chk("rst_fwd_b", ib.fwd_valid_o, 0);

      // C_STAGES=1: ADD 5+7 -> 12
      iss_b(1, 4'd0, 32'd5, 32'd7, 6'd3, 1, 5'd9);
      #1;
      chk("add_wk_v", ib.wakeup_valid_o, 1);
      chk("add_wk_d", ib.wakeup_dest_o, 3);
      tick();
      iss_b(0, 0, 0, 0, 0, 0, 0);
      chk("add_fv1", ib.fwd_valid_o, 2'b01);
      chk("add_d0", ib.fwd_data_o[31:0], 12);
      chk("add_t0", ib.fwd_dest_o[5:0], 3);
      tick();
      chk("add_fv2", ib.fwd_valid_o, 2'b10);
      chk("add_d1", ib.fwd_data_o[63:32], 12);
      chk("add_cv", ib.cmp_valid_o, 1);
      chk("add_rob", ib.cmp_rob_o, 9);
      tick();
      chk("add_done", ib.cmp_valid_o, 0);

      // C_STAGES=3: four back-to-back ops complete in cycles 4..7
      for (int i = 0; i < 8; i++) begin
         if (i < 4)
            iss_a(1, t_op[i], t_a[i], t_b[i], (i == 3), 32'h1234,
                  6'd5, 1, 5'(i + 1));
         else
            iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
         if (i >= 3 && i <= 6) begin
            chk("b2b_cv", ia.cmp_valid_o, 1);
            chk("b2b_rob", ia.cmp_rob_o, 5'(i - 2));
            chk("b2b_data", ia.fwd_data_o[127:96], t_exp[i-3]);
         end else begin
            chk("b2b_idle", ia.cmp_valid_o, 0);
         end
      end
      chk("b2b_icnt", ia.pmu_issue_cnt_o, 4);

      // Full pipe, then 3 stall cycles with an issue pending
      for (int i = 0; i < 4; i++) begin
         iss_a(1, 4'd0, 32'(i), 32'd100, 0, 0, 6'd2, 1, 5'(10 + i));
         tick();
      end
      iss_a(1, 4'd0, 0, 0, 0, 0, 6'd2, 1, 5'd31);
      ia.cmp_ready_i = 1'b0;
      #1;
      chk("stl_ready", ia.iss_ready_o, 0);
      chk("stl_wk", ia.wakeup_valid_o, 0);
      tick(); tick(); tick();
      chk("stl_fv", ia.fwd_valid_o, 4'hF);
      chk("stl_rob", ia.cmp_rob_o, 10);
      chk("stl_d0", ia.fwd_data_o[31:0], 103);
      chk("stl_d3", ia.fwd_data_o[127:96], 100);
      chk("stl_scnt", ia.pmu_stall_cnt_o, 3);
      chk("stl_icnt", ia.pmu_issue_cnt_o, 8);
      iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ia.cmp_ready_i = 1'b1;
      #1;
      chk("drn_rob0", ia.cmp_rob_o, 10);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("drn_rob", ia.cmp_rob_o, 5'(10 + i));
         chk("drn_cv", ia.cmp_valid_o, 1);
      end
      tick();
      chk("drn_end", ia.cmp_valid_o, 0);

      // Flush during stall, two ops in flight, issue present
      iss_a(1, 4'd0, 1, 1, 0, 0, 6'd4, 1, 5'd20);
      tick();
      iss_a(1, 4'd0, 2, 2, 0, 0, 6'd4, 1, 5'd21);
      tick();
      iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("fl_pre_rob", ia.cmp_rob_o, 20);
      ia.cmp_ready_i = 1'b0;
      flush = 1'b1;
      iss_a(1, 4'd0, 3, 3, 0, 0, 6'd7, 1, 5'd22);
      tick();
      flush = 1'b0;
      iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ia.cmp_ready_i = 1'b1;
      chk("fl_fv", ia.fwd_valid_o, 0);
      chk("fl_cv", ia.cmp_valid_o, 0);
      chk("fl_ready", ia.iss_ready_o, 1);
      chk("fl_icnt", ia.pmu_issue_cnt_o, 10);
      chk("fl_scnt", ia.pmu_stall_cnt_o, 4);

      // ALU coverage in slot 0
      for (int i = 0; i < 7; i++) begin
         iss_a(1, u_op[i], u_a[i], u_b[i], 0, 0, 6'd1, 1, 5'd1);
         tick();
         chk("alu", ia.fwd_data_o[31:0], u_exp[i]);
      end
      iss_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_icnt", ia.pmu_issue_cnt_o, 17);

      // Flush with completion accepted; flush-cycle issue discarded
      iss_b(1, 4'd0, 1, 2, 6'd4, 1, 5'd5);
      tick();
      iss_b(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("bfl_cv", ib.cmp_valid_o, 1);
      chk("bfl_rob", ib.cmp_rob_o, 5);
      flush = 1'b1;
      iss_b(1, 4'd0, 1, 2, 6'd4, 1, 5'd6);
      #1;
      chk("bfl_wk", ib.wakeup_valid_o, 1);
      tick();
      flush = 1'b0;
      iss_b(0, 0, 0, 0, 0, 0, 0);
      chk("bfl_cv2", ib.cmp_valid_o, 0);
      chk("bfl_fv", ib.fwd_valid_o, 0);
      chk("bfl_icnt", ib.pmu_issue_cnt_o, 2);

      // dest=0 and wr=0 ops still complete
      iss_b(1, 4'd0, 1, 1, 6'd0, 1, 5'd7);
      #1;
      chk("d0_wk", ib.wakeup_valid_o, 0);
      tick();
      iss_b(1, 4'd0, 1, 1, 6'd6, 0, 5'd8);
      #1;
      chk("w0_wk", ib.wakeup_valid_o, 0);
      chk("d0_fv", ib.fwd_valid_o, 0);
      tick();
      iss_b(0, 0, 0, 0, 0, 0, 0);
      chk("d0_fv2", ib.fwd_valid_o, 0);
      chk("d0_cv", ib.cmp_valid_o, 1);
      chk("d0_rob", ib.cmp_rob_o, 7);
      tick();
      chk("w0_fv", ib.fwd_valid_o, 0);
      chk("w0_rob", ib.cmp_rob_o, 8);
      chk("sat_icnt4", ib.pmu_issue_cnt_o, 3);
      tick();

      // Fifth issue stays saturated, then reset mid-stream
      iss_b(1, 4'd0, 1, 1, 6'd2, 1, 5'd9);
      tick();
      iss_b(0, 0, 0, 0, 0, 0, 0);
      chk("sat_icnt5", ib.pmu_issue_cnt_o, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_icnt", ib.pmu_issue_cnt_o, 0);
      chk("rs_cv", ib.cmp_valid_o, 0);
      chk("rs_fv", ib.fwd_valid_o, 0);
      chk("rs_icnt_a", ia.pmu_issue_cnt_o, 0);
      chk("rs_scnt_a", ia.pmu_stall_cnt_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ixu_pipe_gen.md
# ixu_pipe_gen

Parametrised integer execute pipe for the IXU, the successor to the fixed two-stage single-cycle pipe. Accepts one issued op per cycle through a valid/ready handshake and computes a 32-bit ALU result in EX. It carries the result through `C_STAGES` forwarding stages, each driving a bypass slot, and presents completion to the ROB with backpressure. Sits between the IXU issue queue/register-file read and the ROB completion port, with saturating PMU counters for issued ops and stall cycles.

## Interface
- `C_STAGES`, 1: post-EX result stages (1..4); 1 reproduces the EX+WB pipe.
- `P_W`, 6: physical register tag width.
- `ROB_W`, 5: ROB index width.
- `C_CNT_W`, 32: PMU counter width (2..32).
- `core_clock_i` in 1: clock.
- `core_reset_i` in 1: reset; synchronous, active-high.
- `core_flush_i` in 1: pipeline flush.
- `iss_valid_i` in 1: issue request.
- `iss_ready_o` out 1: pipe can accept.
- `iss_rob_i` in ROB_W: ROB index.
- `iss_op_i` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB; 11-15 give result 0.
- `iss_dest_i` in P_W: destination tag.
- `iss_wr_i` in 1: op writes a register.
- `iss_imm_sel_i` in 1: b = immediate.
- `iss_imm_i` in 32: immediate.
- `rs1_data_i`, `rs2_data_i` in 32: operands.
- `wakeup_dest_o` out P_W, `wakeup_valid_o` out 1: early wakeup.
- `fwd_valid_o` out C_STAGES+1: per-slot bypass valid.
- `fwd_dest_o` out (C_STAGES+1)*P_W: per-slot tag; slot i at bits [i*P_W +: P_W].
- `fwd_data_o` out (C_STAGES+1)*32: per-slot data.
- `cmp_valid_o` out 1: completion valid.
- `cmp_ready_i` in 1: ROB accepts completion.
- `cmp_rob_o` out ROB_W: completing ROB index.
- `pmu_issue_cnt_o` out C_CNT_W: accepted issues.
- `pmu_stall_cnt_o` out C_CNT_W: stall cycles.

## Operation
- Stages: EX (slot 0), then S1..S_C_STAGES (slots 1..C_STAGES). Each stage holds valid, wr, dest, rob, data. EX data is combinational from EX operand registers; S_i data is registered.
- `stall = cmp_valid_o & ~cmp_ready_i`; `iss_ready_o = ~stall`. This is combinational from `cmp_ready_i`.
- Accept when `iss_valid_i & iss_ready_o`. EX loads a=rs1, b=(imm_sel ? imm : rs2), op, dest, rob, wr, valid=1. If not accepting and not stalled, EX valid loads 0.
- While stalled, every stage holds. There is no bubble collapsing.
- ALU rules:
  - SUB is a-b.
  - SLT/SLTU give {31'b0, a<b} signed/unsigned.
  - Shifts use b[4:0]; SRA sign-extends.
  - PASSB gives b.
  - All arithmetic wraps mod 2^32.
- `fwd_valid_o[i] = stage_i.valid & stage_i.wr & (stage_i.dest != 0)`. Dest/data slots are driven regardless of valid.
- `wakeup_dest_o = iss_dest_i`; `wakeup_valid_o = iss_valid_i & iss_ready_o & iss_wr_i & (iss_dest_i != 0)`.
- `cmp_valid_o` is S_C_STAGES valid; `cmp_rob_o` is its rob. A completion is retired when `cmp_valid_o & cmp_ready_i`.
- Flush: all stage valid bits clear at the next edge, overriding stall. An issue presented in the flush cycle is discarded and not counted. Wakeup is still driven that cycle; the scheduler also flushes.
- Counters:
  - `pmu_issue_cnt_o` increments per accepted, non-flushed issue.
  - `pmu_stall_cnt_o` increments per stall cycle.
  - Both saturate at all-ones and are cleared only by reset, not by flush.

## Timing
- Reset, at the first edge with reset high: all valid bits and both counters go to 0. So `iss_ready_o`=1, `cmp_valid_o`=0, all `fwd_valid_o`=0, wakeup_valid follows inputs. Data/tag registers are don't-care but slot outputs remain defined.
- Reset dominates flush and stall. Reset mid-stall drops all in-flight ops.
- Issue accepted in cycle k: slot 0 is valid in k+1, slot i in k+1+i, and completion is offered in k+1+C_STAGES if no stall.
- Each stall cycle adds one cycle to every in-flight op.
- Back-to-back issue sustains 1 op/cycle with `cmp_ready_i`=1.
- Full pipe (C_STAGES+1 ops) plus stall: no op lost or duplicated, order preserved.
- Flush while `cmp_valid_o`=1 and `cmp_ready_i`=1: that completion is still retired this cycle, and `cmp_valid_o`=0 next cycle.

## Test plan
- C_STAGES=1: issue ADD 5+7 dest 3 in cycle 0 → fwd slot0 valid, data 12 in cycle 1; slot1 valid in cycle 2; `cmp_valid_o`=1 with rob in cycle 2.
- C_STAGES=3: 4 back-to-back ops (SUB 0-1=0xFFFFFFFF, SRA 0x80000000>>4=0xF8000000, SLTU 1<0xFFFFFFFF=1, PASSB imm 0x1234) → completions in cycles 4..7 in order with correct data; issue cnt=4.
- Hold `cmp_ready_i`=0 for 3 cycles with full pipe → `iss_ready_o`=0, all slots frozen, stall cnt=3; release → drain in order with no duplicates.
- Flush during stall with 2 ops in flight and issue present → next cycle all valids 0, `iss_ready_o`=1, issue cnt unchanged.
- dest=0 or wr=0 op → fwd_valid never 1, wakeup_valid 0, completion still delivered.
- C_CNT_W=2: 5 accepted issues → cnt 3 (saturated); assert reset mid-stream → cnt 0 and cmp_valid 0 next cycle.
